// File: rtl/shift_sequencer_pkg.sv
// Shared shifter definitions: op and state encodings, default widths.
// Also hosts the lowest-set-bit helper used when SHIFT_SEQ_SKIP_ZERO_EN is set.
package shift_sequencer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [1:0] low_bit(
    input logic [3:0] c
  );
    logic [1:0] r;
    if (c[0])      r = 2'd0;
    else if (c[1]) r = 2'd1;
    else if (c[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift/rotate stage (1, 2, 4 or 8 positions).
// Purely combinational; reused every cycle by shift_sequencer.
module shift_stage
  import shift_sequencer_pkg::*;
(
  input  logic [15:0] data,
  input  logic [1:0]  op,
  input  logic [1:0]  amt_sel,
  output logic [15:0] shifted
);

  logic [4:0]  amt;
  logic [31:0] dbl;
  logic [31:0] dbl_l;
  logic [31:0] dbl_r;

  assign amt = 5'd1 << amt_sel;
  assign dbl = {data, data};
  // Rotates fall out of shifting the doubled word
  assign dbl_l = dbl << amt;
  assign dbl_r = dbl >> amt;

  always_comb begin
    shifted = data;
    unique case (op)
      OP_ROL:  shifted = dbl_l[31:16];
      OP_SLL:  shifted = data << amt;
      OP_ROR:  shifted = dbl_r[15:0];
      OP_SRL:  shifted = data >> amt;
      default: shifted = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer, one power-of-two stage per clock.
// Define SHIFT_SEQ_SKIP_ZERO_EN to visit only set count bits.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [CNT_W-1:0]  req_cnt,
  input  logic [1:0]        req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        amt_sel;
  logic [15:0]       stage_out;

`ifdef SHIFT_SEQ_SKIP_ZERO_EN
  assign amt_sel = low_bit(cnt_q);
`else
  assign amt_sel = k_q;
`endif

  shift_stage u_stage (
    .data    (data_q),
    .op      (op_q),
    .amt_sel (amt_sel),
    .shifted (stage_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          data_d  = req_data;
          cnt_d   = req_cnt;
          op_d    = req_op;
          k_d     = '0;
          state_d = ST_SHIFT;
`ifdef SHIFT_SEQ_SKIP_ZERO_EN
          if (req_cnt == '0) state_d = ST_DONE;
`endif
        end
      end
      ST_SHIFT: begin
`ifdef SHIFT_SEQ_SKIP_ZERO_EN
        data_d = stage_out;
        cnt_d  = cnt_q & (cnt_q - 1'b1);
        if (cnt_d == '0) state_d = ST_DONE;
`else
        if (cnt_q[k_q]) data_d = stage_out;
        k_d = k_q + 2'd1;
        if (k_q == 2'(CNT_W - 1)) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) ||
                     (state_q == ST_DONE);
  assign rsp_data  = rsp_valid ? data_q : '0;

endmodule
